// File: rtl/serdes_rx_pattern_checker.sv
// RX pattern checker for the CC_SERDES loopback build: hunts the K28.5 comma, latches the byte
// rotation, verifies each following word against the fixed TX pattern and keeps lock/error stats.
module serdes_rx_pattern_checker #(
  parameter logic [63:0] EXP_DATA  = 64'h0000_0000_00CA_FEBC,
  parameter logic [7:0]  EXP_K     = 8'h01,
  parameter int          LOCK_GOOD = 4,
  parameter int          LOCK_BAD  = 3,
  parameter int          CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_reset_done_i,
  input  logic             rx_valid_i,
  input  logic [63:0]      rx_data_i,
  input  logic [7:0]       rx_char_is_k_i,
  input  logic [7:0]       rx_not_in_table_i,
  input  logic [7:0]       rx_disp_err_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic [2:0]       align_o,
  output logic             err_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [1:0]       state_o
);

  // Handshake: rx_valid_i qualifies the word on the same cycle; there is no backpressure,
  // so a word with rx_valid_i=0 is simply ignored by every stage.

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HUNT   = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  localparam logic [3:0] GOOD_LAST = 4'(LOCK_GOOD - 1);
  localparam logic [3:0] BAD_LAST  = 4'(LOCK_BAD - 1);

  // Stage 1: input register
  logic [63:0] data_q;
  logic [7:0]  k_q;
  logic [7:0]  nit_q;
  logic [7:0]  disp_q;
  logic        valid_q;

  // Stage 2: FSM, alignment, run counters, statistics
  logic [1:0]       state_q;
  logic [2:0]       align_q;
  logic [3:0]       good_run_q;
  logic [3:0]       bad_run_q;
  logic             locked_q;
  logic             err_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic [63:0] rot_data;
  logic [7:0]  rot_k;
  logic        match;
  logic        hit;
  logic [2:0]  hit_idx;
  logic        word_inc;
  logic        err_inc;

  function automatic logic [2:0] wrap_add(input logic [2:0] a, input logic [2:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      k_q     <= '0;
      nit_q   <= '0;
      disp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= rx_data_i;
      k_q     <= rx_char_is_k_i;
      nit_q   <= rx_not_in_table_i;
      disp_q  <= rx_disp_err_i;
      valid_q <= rx_valid_i;
    end
  end

  // Rotate right by align bytes: output byte i comes from input byte (i + align) mod 8.
  always_comb begin
    rot_data = '0;
    rot_k    = '0;
    for (int i = 0; i < 8; i++) begin
      rot_data[8*i +: 8] = data_q[8*wrap_add(3'(i), align_q) +: 8];
      rot_k[i]           = k_q[wrap_add(3'(i), align_q)];
    end
  end

  assign match = (rot_data == EXP_DATA) && (rot_k == EXP_K) &&
                 (nit_q == 8'h00) && (disp_q == 8'h00);

  // Scan from the top so the lowest comma byte wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (k_q[j] && (data_q[8*j +: 8] == EXP_DATA[7:0])) begin
        hit     = 1'b1;
        hit_idx = 3'(j);
      end
    end
  end

  assign word_inc = rx_reset_done_i && (state_q == S_LOCKED) && valid_q;
  assign err_inc  = word_inc && !match;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      align_q    <= 3'd0;
      good_run_q <= 4'd0;
      bad_run_q  <= 4'd0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (!rx_reset_done_i) begin
        state_q  <= S_IDLE;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_HUNT;
          S_HUNT: begin
            if (valid_q && hit) begin
              align_q    <= hit_idx;
              good_run_q <= 4'd0;
              state_q    <= S_VERIFY;
            end
          end
          S_VERIFY: begin
            if (valid_q) begin
              if (!match) begin
                state_q <= S_HUNT;
              end else if (good_run_q == GOOD_LAST) begin
                state_q   <= S_LOCKED;
                locked_q  <= 1'b1;
                bad_run_q <= 4'd0;
              end else begin
                good_run_q <= good_run_q + 4'd1;
              end
            end
          end
          S_LOCKED: begin
            if (valid_q) begin
              if (match) begin
                bad_run_q <= 4'd0;
              end else begin
                err_q <= 1'b1;
                if (bad_run_q == BAD_LAST) begin
                  state_q  <= S_HUNT;
                  locked_q <= 1'b0;
                end else begin
                  bad_run_q <= bad_run_q + 4'd1;
                end
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Saturating statistics; clear wins over a coincident increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (word_inc && !(&word_cnt_q)) word_cnt_q <= word_cnt_q + 1'b1;
      if (err_inc && !(&err_cnt_q))   err_cnt_q  <= err_cnt_q + 1'b1;
    end
  end

  assign locked_o   = locked_q;
  assign align_o    = align_q;
  assign err_o      = err_q;
  assign word_cnt_o = word_cnt_q;
  assign err_cnt_o  = err_cnt_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_serdes_rx_pattern_checker.sv
// Directed bench for serdes_rx_pattern_checker: default instance plus a narrow-counter,
// long-bad-run instance for saturation checks.
module tb_serdes_rx_pattern_checker;

  localparam logic [63:0] GOOD_D = 64'h0000_0000_00CA_FEBC;
  localparam logic [63:0] ROT_D  = 64'h00CA_FEBC_0000_0000;
  localparam logic [63:0] JUNK_D = 64'hDEAD_BEEF_1234_5678;
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_HUNT   = 2'd1;
  localparam logic [1:0]  ST_VERIFY = 2'd2;
  localparam logic [1:0]  ST_LOCKED = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        valid = 1'b0;
  logic [63:0] data = '0;
  logic [7:0]  kmask = '0;
  logic [7:0]  nit = '0;
  logic [7:0]  disp = '0;
  logic        clear = 1'b0;

  logic        locked, err;
  logic [2:0]  align;
  logic [31:0] word_cnt, err_cnt;
  logic [1:0]  state;

  logic        locked5, err5;
  logic [2:0]  align5;
  logic [3:0]  word_cnt5, err_cnt5;
  logic [1:0]  state5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serdes_rx_pattern_checker dut (
    .clk_i(clk), .rst_i(rst), .rx_reset_done_i(ready), .rx_valid_i(valid),
    .rx_data_i(data), .rx_char_is_k_i(kmask), .rx_not_in_table_i(nit), .rx_disp_err_i(disp),
    .clear_i(clear), .locked_o(locked), .align_o(align), .err_o(err),
    .word_cnt_o(word_cnt), .err_cnt_o(err_cnt), .state_o(state)
  );

  serdes_rx_pattern_checker #(.CNT_W(4), .LOCK_BAD(15)) dut5 (
    .clk_i(clk), .rst_i(rst), .rx_reset_done_i(ready), .rx_valid_i(valid),
    .rx_data_i(data), .rx_char_is_k_i(kmask), .rx_not_in_table_i(nit), .rx_disp_err_i(disp),
    .clear_i(clear), .locked_o(locked5), .align_o(align5), .err_o(err5),
    .word_cnt_o(word_cnt5), .err_cnt_o(err_cnt5), .state_o(state5)
  );

  // Present one word for one clock; returns #1 after the edge that captured it.
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic [7:0] n,
                      input logic v);
    data = d; kmask = k; nit = n; disp = 8'h00; valid = v;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0; valid = 1'b0; clear = 1'b0;
    data = '0; kmask = '0; nit = '0; disp = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic lock_plain();
    ready = 1'b1;
    repeat (6) send(GOOD_D, 8'h01, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b0; valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({locked, align, err, word_cnt, err_cnt, state} !== '0) begin
      $display("FAIL reset_outputs: got lock=%0b align=%0d err=%0b wc=%0d ec=%0d st=%0d want all 0",
               locked, align, err, word_cnt, err_cnt, state);
      n_fail++;
    end
    rst = 1'b0;
  endtask

  task automatic test_lock_plain();
    do_reset();
    ready = 1'b1;
    repeat (5) send(GOOD_D, 8'h01, 8'h00, 1'b1);
    n_checks++;
    if (locked !== 1'b0 || state !== ST_VERIFY) begin
      $display("FAIL plain_not_yet_locked: got lock=%0b st=%0d want lock=0 st=2", locked, state);
      n_fail++;
    end
    send(GOOD_D, 8'h01, 8'h00, 1'b1);
    n_checks++;
    if (locked !== 1'b1 || state !== ST_LOCKED || align !== 3'd0 || word_cnt !== 32'd0) begin
      $display("FAIL plain_locked: got lock=%0b st=%0d align=%0d wc=%0d want 1 3 0 0",
               locked, state, align, word_cnt);
      n_fail++;
    end
    send(GOOD_D, 8'h01, 8'h00, 1'b1);
    n_checks++;
    if (word_cnt !== 32'd1) begin
      $display("FAIL plain_first_count: got wc=%0d want 1", word_cnt);
      n_fail++;
    end
    repeat (2) send(GOOD_D, 8'h01, 8'h00, 1'b1);
    n_checks++;
    if (word_cnt !== 32'd3 || err_cnt !== 32'd0 || err !== 1'b0) begin
      $display("FAIL plain_counts: got wc=%0d ec=%0d err=%0b want 3 0 0", word_cnt, err_cnt, err);
      n_fail++;
    end
  endtask

  task automatic test_lock_rotated();
    do_reset();
    ready = 1'b1;
    repeat (5) send(ROT_D, 8'h10, 8'h00, 1'b1);
    n_checks++;
    if (locked !== 1'b0 || align !== 3'd4) begin
      $display("FAIL rot_verify: got lock=%0b align=%0d want lock=0 align=4", locked, align);
      n_fail++;
    end
    send(ROT_D, 8'h10, 8'h00, 1'b1);
    n_checks++;
    if (locked !== 1'b1 || align !== 3'd4 || word_cnt !== 32'd0) begin
      $display("FAIL rot_locked: got lock=%0b align=%0d wc=%0d want 1 4 0", locked, align, word_cnt);
      n_fail++;
    end
  endtask

  task automatic test_errors();
    do_reset();
    lock_plain();
    send(GOOD_D, 8'h01, 8'h04, 1'b1);
    send(GOOD_D, 8'h01, 8'h00, 1'b1);
    n_checks++;
    if (err !== 1'b1 || err_cnt !== 32'd1 || locked !== 1'b1 || word_cnt !== 32'd2) begin
      $display("FAIL single_err: got err=%0b ec=%0d lock=%0b wc=%0d want 1 1 1 2",
               err, err_cnt, locked, word_cnt);
      n_fail++;
    end
    clear = 1'b1;
    send(GOOD_D, 8'h01, 8'h00, 1'b1);
    clear = 1'b0;
    n_checks++;
    if (err !== 1'b0 || err_cnt !== 32'd0 || word_cnt !== 32'd0 || locked !== 1'b1) begin
      $display("FAIL pulse_and_clear: got err=%0b ec=%0d wc=%0d lock=%0b want 0 0 0 1",
               err, err_cnt, word_cnt, locked);
      n_fail++;
    end
    repeat (3) send(GOOD_D, 8'h01, 8'h04, 1'b1);
    n_checks++;
    if (locked !== 1'b1 || err_cnt !== 32'd2) begin
      $display("FAIL two_bad_keep_lock: got lock=%0b ec=%0d want 1 2", locked, err_cnt);
      n_fail++;
    end
    send(GOOD_D, 8'h01, 8'h00, 1'b1);
    n_checks++;
    if (locked !== 1'b0 || err_cnt !== 32'd3 || state !== ST_HUNT || err !== 1'b1 ||
        word_cnt !== 32'd4) begin
      $display("FAIL third_bad_unlock: got lock=%0b ec=%0d st=%0d err=%0b wc=%0d want 0 3 1 1 4",
               locked, err_cnt, state, err, word_cnt);
      n_fail++;
    end
  endtask

  task automatic test_ready_drop();
    do_reset();
    ready = 1'b1;
    repeat (8) send(ROT_D, 8'h10, 8'h00, 1'b1);
    ready = 1'b0;
    send(ROT_D, 8'h10, 8'h00, 1'b1);
    ready = 1'b1;
    n_checks++;
    if (locked !== 1'b0 || state !== ST_IDLE || word_cnt !== 32'd2 || align !== 3'd4) begin
      $display("FAIL ready_drop: got lock=%0b st=%0d wc=%0d align=%0d want 0 0 2 4",
               locked, state, word_cnt, align);
      n_fail++;
    end
    repeat (5) send(ROT_D, 8'h10, 8'h00, 1'b1);
    n_checks++;
    if (locked !== 1'b0 || state !== ST_VERIFY) begin
      $display("FAIL relock_early: got lock=%0b st=%0d want 0 2", locked, state);
      n_fail++;
    end
    send(ROT_D, 8'h10, 8'h00, 1'b1);
    n_checks++;
    if (locked !== 1'b1 || word_cnt !== 32'd2 || align !== 3'd4) begin
      $display("FAIL relock: got lock=%0b wc=%0d align=%0d want 1 2 4", locked, word_cnt, align);
      n_fail++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    lock_plain();
    repeat (14) send(GOOD_D, 8'h01, 8'h04, 1'b1);
    send(GOOD_D, 8'h01, 8'h00, 1'b1);
    n_checks++;
    if (err_cnt5 !== 4'hE || locked5 !== 1'b1) begin
      $display("FAIL sat_pre: got ec=%0h lock=%0b want e 1", err_cnt5, locked5);
      n_fail++;
    end
    repeat (6) send(GOOD_D, 8'h01, 8'h04, 1'b1);
    send(GOOD_D, 8'h01, 8'h00, 1'b1);
    n_checks++;
    if (err_cnt5 !== 4'hF || word_cnt5 !== 4'hF || locked5 !== 1'b1 || err5 !== 1'b1) begin
      $display("FAIL sat_hold: got ec=%0h wc=%0h lock=%0b err=%0b want f f 1 1",
               err_cnt5, word_cnt5, locked5, err5);
      n_fail++;
    end
    send(GOOD_D, 8'h01, 8'h04, 1'b1);
    clear = 1'b1;
    send(GOOD_D, 8'h01, 8'h00, 1'b1);
    clear = 1'b0;
    n_checks++;
    if (err_cnt5 !== 4'h0 || word_cnt5 !== 4'h0 || err5 !== 1'b1 || locked5 !== 1'b1) begin
      $display("FAIL clear_with_err: got ec=%0h wc=%0h err=%0b lock=%0b want 0 0 1 1",
               err_cnt5, word_cnt5, err5, locked5);
      n_fail++;
    end
  endtask

  task automatic test_valid_gaps_and_rst();
    do_reset();
    ready = 1'b1;
    send(GOOD_D, 8'h01, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(JUNK_D, 8'hFF, 8'hFF, 1'b0);
      send(GOOD_D, 8'h01, 8'h00, 1'b1);
    end
    n_checks++;
    if (locked !== 1'b0 || state !== ST_VERIFY) begin
      $display("FAIL gaps_not_yet: got lock=%0b st=%0d want 0 2", locked, state);
      n_fail++;
    end
    send(JUNK_D, 8'hFF, 8'hFF, 1'b0);
    n_checks++;
    if (locked !== 1'b1 || err_cnt !== 32'd0) begin
      $display("FAIL gaps_locked: got lock=%0b ec=%0d want 1 0", locked, err_cnt);
      n_fail++;
    end
    send(GOOD_D, 8'h01, 8'h00, 1'b1);
    send(GOOD_D, 8'h01, 8'h00, 1'b1);
    n_checks++;
    if (word_cnt !== 32'd1) begin
      $display("FAIL gaps_count: got wc=%0d want 1", word_cnt);
      n_fail++;
    end
    rst = 1'b1;
    send(GOOD_D, 8'h01, 8'h00, 1'b1);
    rst = 1'b0;
    n_checks++;
    if ({locked, align, err, word_cnt, err_cnt, state} !== '0) begin
      $display("FAIL mid_rst: got lock=%0b align=%0d err=%0b wc=%0d ec=%0d st=%0d want all 0",
               locked, align, err, word_cnt, err_cnt, state);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_lock_plain();
    test_lock_rotated();
    test_errors();
    test_ready_drop();
    test_saturation();
    test_valid_gaps_and_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
